// File: rtl/status_led_pkg.sv
// Shared types and widths for the status LED controller.
package status_led_pkg;

    localparam int ModeW = 3;
    localparam int DutyW = 8;
    localparam int CodeW = 4;

    typedef enum logic [ModeW-1:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_PWM   = 3'd3,
        MODE_CODE  = 3'd4
    } led_mode_e;

    typedef enum logic [1:0] {
        CODE_IDLE,
        CODE_ON,
        CODE_OFF,
        CODE_GAP
    } code_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/status_led_chan.sv
// One LED channel: blink/fast timers, optional PWM counter, blink-code FSM, alert latch.
// PWM support is built only when STATUS_LED_PWM_EN is defined; otherwise mode 3 lights steadily.
//
// state     | meaning
// CODE_IDLE | dark, samples code_i each clk, nonzero starts a sequence
// CODE_ON   | lit for PulseTicks ticks
// CODE_OFF  | dark for PulseTicks ticks, then next pulse or gap
// CODE_GAP  | dark for GapTicks ticks after the last pulse
module status_led_chan
    import status_led_pkg::*;
#(
    parameter int BlinkTicks = 500,
    parameter int FastTicks  = 62,
    parameter int PulseTicks = 200,
    parameter int GapTicks   = 1500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [ModeW-1:0] mode_i,
    input  logic [DutyW-1:0] duty_i,
    input  logic [CodeW-1:0] code_i,
    input  logic             alert_set_i,
    input  logic             alert_clr_i,
    output logic             led_o,
    output logic             alert_o
);

    localparam int MaxTicks = max_int(max_int(BlinkTicks, FastTicks), max_int(PulseTicks, GapTicks));
    localparam int CntW = $clog2(MaxTicks + 1);
    localparam logic [CntW-1:0] BlinkLd = CntW'(BlinkTicks - 1);
    localparam logic [CntW-1:0] FastLd  = CntW'(FastTicks - 1);
    localparam logic [CntW-1:0] PulseLd = CntW'(PulseTicks - 1);
    localparam logic [CntW-1:0] GapLd   = CntW'(GapTicks - 1);

    logic [ModeW-1:0] mode_q, mode_d;
    logic             alert_q, alert_d;
    logic [CntW-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_lit_q, blink_lit_d;
    logic [CntW-1:0]  fast_cnt_q, fast_cnt_d;
    logic             fast_lit_q, fast_lit_d;
    code_state_e      code_st_q, code_st_d;
    logic [CntW-1:0]  code_cnt_q, code_cnt_d;
    logic [CodeW-1:0] rem_q, rem_d;
    logic             led_q, led_d;
    logic             mode_chg;
    logic             mode_lit;
    logic             pwm_lit;

    assign mode_chg = (mode_i != mode_q);

`ifdef STATUS_LED_PWM_EN
    logic [DutyW-1:0] pwm_q, pwm_d;

    always_comb pwm_d = mode_chg ? '0 : pwm_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pwm_q <= '0;
        else       pwm_q <= pwm_d;
    end

    assign pwm_lit = (pwm_d < duty_i);
`else
    logic unused_duty;
    assign unused_duty = ^duty_i;
    assign pwm_lit = 1'b1;
`endif

    always_comb begin
        mode_d  = mode_i;
        alert_d = alert_set_i | (alert_q & ~alert_clr_i);

        blink_cnt_d = blink_cnt_q;
        blink_lit_d = blink_lit_q;
        if (mode_chg) begin
            blink_cnt_d = BlinkLd;
            blink_lit_d = 1'b1;
        end else if (tick_i) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d = BlinkLd;
                blink_lit_d = ~blink_lit_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
            end
        end

        // Fast timer is held at its lit phase until the alert has actually latched.
        fast_cnt_d = fast_cnt_q;
        fast_lit_d = fast_lit_q;
        if (!alert_q) begin
            fast_cnt_d = FastLd;
            fast_lit_d = 1'b1;
        end else if (tick_i) begin
            if (fast_cnt_q == '0) begin
                fast_cnt_d = FastLd;
                fast_lit_d = ~fast_lit_q;
            end else begin
                fast_cnt_d = fast_cnt_q - 1'b1;
            end
        end

        code_st_d  = code_st_q;
        code_cnt_d = code_cnt_q;
        rem_d      = rem_q;
        if (mode_chg) begin
            code_st_d  = CODE_IDLE;
            code_cnt_d = '0;
            rem_d      = '0;
        end else begin
            case (code_st_q)
                CODE_IDLE: if (code_i != '0) begin
                    rem_d      = code_i;
                    code_st_d  = CODE_ON;
                    code_cnt_d = PulseLd;
                end
                CODE_ON: if (tick_i) begin
                    if (code_cnt_q == '0) begin
                        code_st_d  = CODE_OFF;
                        code_cnt_d = PulseLd;
                    end else begin
                        code_cnt_d = code_cnt_q - 1'b1;
                    end
                end
                CODE_OFF: if (tick_i) begin
                    if (code_cnt_q != '0) begin
                        code_cnt_d = code_cnt_q - 1'b1;
                    end else if (rem_q > 4'd1) begin
                        rem_d      = rem_q - 1'b1;
                        code_st_d  = CODE_ON;
                        code_cnt_d = PulseLd;
                    end else begin
                        code_st_d  = CODE_GAP;
                        code_cnt_d = GapLd;
                    end
                end
                default: if (tick_i) begin
                    if (code_cnt_q == '0) code_st_d = CODE_IDLE;
                    else                  code_cnt_d = code_cnt_q - 1'b1;
                end
            endcase
        end

        case (mode_i)
            MODE_ON:    mode_lit = 1'b1;
            MODE_BLINK: mode_lit = blink_lit_d;
            MODE_PWM:   mode_lit = pwm_lit;
            MODE_CODE:  mode_lit = (code_st_d == CODE_ON);
            default:    mode_lit = 1'b0;
        endcase

        led_d = alert_d ? fast_lit_d : mode_lit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= '0;
            alert_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_lit_q <= 1'b0;
            fast_cnt_q  <= '0;
            fast_lit_q  <= 1'b0;
            code_st_q   <= CODE_IDLE;
            code_cnt_q  <= '0;
            rem_q       <= '0;
            led_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            alert_q     <= alert_d;
            blink_cnt_q <= blink_cnt_d;
            blink_lit_q <= blink_lit_d;
            fast_cnt_q  <= fast_cnt_d;
            fast_lit_q  <= fast_lit_d;
            code_st_q   <= code_st_d;
            code_cnt_q  <= code_cnt_d;
            rem_q       <= rem_d;
            led_q       <= led_d;
        end
    end

    assign led_o   = led_q;
    assign alert_o = alert_q;

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED controller: shared base-tick prescaler, per-channel engines, pin polarity.
// Build with STATUS_LED_PWM_EN defined to enable PWM dimming in mode 3.
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int   NumLeds    = 2,
    parameter int   TickDiv    = 100000,
    parameter int   BlinkTicks = 500,
    parameter int   FastTicks  = 62,
    parameter int   PulseTicks = 200,
    parameter int   GapTicks   = 1500,
    parameter logic ActiveLow  = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ModeW*NumLeds-1:0] mode_i,
    input  logic [DutyW*NumLeds-1:0] duty_i,
    input  logic [CodeW*NumLeds-1:0] code_i,
    input  logic [NumLeds-1:0]       alert_set_i,
    input  logic [NumLeds-1:0]       alert_clr_i,
    output logic [NumLeds-1:0]       led_o,
    output logic [NumLeds-1:0]       alert_o,
    output logic                     tick_o
);

    localparam int PreW = $clog2(TickDiv);
    localparam logic [PreW-1:0] PreLast = PreW'(TickDiv - 1);

    logic [PreW-1:0]    pre_q, pre_d;
    logic               tick;
    logic [NumLeds-1:0] led_raw;

    assign tick = (pre_q == PreLast);

    always_comb pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    assign tick_o = tick;

    for (genvar i = 0; i < NumLeds; i++) begin : g_chan
        status_led_chan #(
            .BlinkTicks (BlinkTicks),
            .FastTicks  (FastTicks),
            .PulseTicks (PulseTicks),
            .GapTicks   (GapTicks)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .tick_i      (tick),
            .mode_i      (mode_i[i*ModeW +: ModeW]),
            .duty_i      (duty_i[i*DutyW +: DutyW]),
            .code_i      (code_i[i*CodeW +: CodeW]),
            .alert_set_i (alert_set_i[i]),
            .alert_clr_i (alert_clr_i[i]),
            .led_o       (led_raw[i]),
            .alert_o     (alert_o[i])
        );
    end

    // Polarity is applied after the register so reset drives the pins dark.
    assign led_o = ActiveLow ? ~led_raw : led_raw;

endmodule

// File: doc/status_led_ctrl.md
Name: status_led_ctrl

Overview:
Parametrised successor to the single free-running heartbeat counter in the FPGA core level. Drives NumLeds indicator LEDs, each with a selectable mode: off, on, blink, PWM dim, or blink-code. A per-channel sticky alert override lets CPU alert or double-fault pulses latch a visible fast-blink until software clears it. Sits in the sys clock domain beside the SoC; mode and code inputs come from a CSR block or tie-offs.

Parameters:
NumLeds, 2, number of LED channels (1..16)
TickDiv, 100000, clk cycles per base tick (>=2); 1 kHz tick at 100 MHz
BlinkTicks, 500, ticks per half-period in BLINK mode (>=1)
FastTicks, 62, ticks per half-period while alert latched (>=1)
PulseTicks, 200, ticks per on-phase and per off-phase of one code pulse (>=1)
GapTicks, 1500, ticks of dark gap after a code sequence (>=1)
ActiveLow, 1'b0, invert led_o at the pin

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
mode_i  in  3*NumLeds  per-channel mode, led_mode_e: 0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 CODE; 5-7 treated as OFF
duty_i  in  8*NumLeds  per-channel PWM duty (0..255)
code_i  in  4*NumLeds  per-channel blink-code count (0..15)
alert_set_i  in  NumLeds  single-cycle pulse; latches the channel alert
alert_clr_i  in  NumLeds  single-cycle pulse; clears the channel alert
led_o  out  NumLeds  registered LED drive
alert_o  out  NumLeds  latched alert state
tick_o  out  1  one-cycle base-tick strobe, for debug

Behaviour:
- Reset: prescaler=0, all channel counters=0, code FSM=IDLE, alert_o=0, tick_o=0, led_o=ActiveLow ? '1 : '0.
- Prescaler: counts 0..TickDiv-1 and wraps. tick_o=1 for exactly the cycle in which the count equals TickDiv-1. All tick counters below advance only on tick.
- led_o is registered: 1-cycle latency from any input change to led_o. ActiveLow inversion is applied after the register.
- Mode change: each channel registers mode_i. When the new value differs from the stored one, that channel's blink, code and PWM state clears on the same edge. BLINK and CODE then begin at their lit phase.
- OFF: dark. ON: lit.
- BLINK: toggles every BlinkTicks ticks; lit first.
- PWM: 8-bit counter per channel, incremented each clk and wrapping 255->0. Lit while counter < duty. duty 0 gives always dark; duty 255 gives 255 of 256 cycles lit.
- CODE FSM, states IDLE, ON, OFF, GAP:
  - IDLE: samples code_i. If the code is 0, stay dark in IDLE. Otherwise latch rem=code and go to ON.
  - ON (lit) lasts PulseTicks ticks, then OFF.
  - OFF (dark) lasts PulseTicks ticks. If rem>1: rem-1 and go to ON; else go to GAP.
  - GAP (dark) lasts GapTicks ticks, then IDLE.
  - code_i changes mid-sequence take effect at the next IDLE sample.
- Alert:
  - alert_set sets the latch and alert_clr clears it. Set and clear in the same cycle: set wins.
  - While the latch is set, the channel ignores its mode and toggles every FastTicks ticks, lit first.
  - The underlying mode state keeps running and resumes unchanged when the latch clears.
- Per-channel tick counters are wide enough for max(BlinkTicks, FastTicks, PulseTicks, GapTicks).

Optional Feature:
STATUS_LED_PWM_EN
- Defined: PWM mode as specified; duty_i is used.
- Undefined: no PWM counters are instantiated, mode 3 behaves as ON, and duty_i is unused (sunk into an unused-signal reduction).

Decomposition:
- status_led_pkg holds:
  - led_mode_e enum (3-bit);
  - code_state_e enum;
  - localparams ModeW=3, DutyW=8, CodeW=4.
- Sub-module status_led_chan (one per channel, generate loop) holds the blink/fast counters, PWM counter, code FSM and alert latch.
- status_led_ctrl holds the shared prescaler and output inversion.

Test Plan:
All scenarios use TickDiv=4, BlinkTicks=2, FastTicks=1, PulseTicks=1, GapTicks=3, NumLeds=2.
1. Reset asserted mid-run with ActiveLow=1 -> led_o=2'b11, alert_o=0, tick_o=0 immediately; first tick_o on the 4th clk after release.
2. mode0=ON then OFF -> led_o[0] follows 1 clk later. mode0=BLINK -> lit 8 clks, dark 8 clks, repeating.
3. mode0=CODE, code0=3 -> lit/dark 4 clks each, three pulses, then dark 12-clk gap, repeat. Changing code0 to 1 mid-pulse -> new count only after the gap. code0=0 -> steady dark.
4. With STATUS_LED_PWM_EN: mode1=PWM, duty1=64 -> 64 lit of every 256 clks; duty1=0 -> never lit. Without the macro: mode1=PWM -> steady lit.
5. Channel 0 in BLINK, pulse alert_set_i[0] -> alert_o[0]=1 next clk, 4-clk toggling. alert_set and alert_clr in the same clk -> stays set. alert_clr alone -> alert_o[0]=0 and blink resumes in its running phase.
6. Channel 1 mode changes from CODE (in GAP) to BLINK and back to CODE -> FSM restarts from IDLE with a lit pulse.
